// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: strobe/result bundle between the RX controller and the
// data-path stages (sampler, start/parity/stop checkers, deserializer).
//   o_data_sample_enable  ctrl -> sampler       high whenever a frame is active
//   o_edge_count          ctrl -> sampler       current oversampling edge index
//   o_start_check_enable  ctrl -> start check   one-cycle strobe
//   o_parity_check_enable ctrl -> parity check  one-cycle strobe
//   o_stop_check_enable   ctrl -> stop check    one-cycle strobe
//   o_deser_enable        ctrl -> deserializer  one-cycle shift strobe
//   i_start_bit_checked   start check -> ctrl   registered, 1 = valid start bit
//   i_parity_error        parity check -> ctrl  registered, 1 = error
//   i_stop_error          stop check -> ctrl    registered, 1 = error
interface uart_rx_ctrl_if #(
  parameter int unsigned PRESCALE_W = 6
);
  logic                  o_data_sample_enable;
  logic [PRESCALE_W-1:0] o_edge_count;
  logic                  o_start_check_enable;
  logic                  o_parity_check_enable;
  logic                  o_stop_check_enable;
  logic                  o_deser_enable;
  logic                  i_start_bit_checked;
  logic                  i_parity_error;
  logic                  i_stop_error;

  modport master (
    output o_data_sample_enable, o_edge_count, o_start_check_enable,
           o_parity_check_enable, o_stop_check_enable, o_deser_enable,
    input  i_start_bit_checked, i_parity_error, i_stop_error
  );

  modport slave (
    input  o_data_sample_enable, o_edge_count, o_start_check_enable,
           o_parity_check_enable, o_stop_check_enable, o_deser_enable,
    output i_start_bit_checked, i_parity_error, i_stop_error
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side UART controller. Detects the start edge, runs
// the oversampling edge counter and bit counter, strobes the data-path
// stages and judges each frame from the registered checker results.
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_rx_in            synchronised serial line, idle high
//   i_prescale         oversampling ratio, latched at frame start (min 8)
//   i_parity_enable    frame carries parity, latched at frame start
//   chk                strobes/results to/from the data-path stages
//   o_data_valid       one-cycle pulse, good frame
//   o_parity_err_flag  one-cycle pulse, parity failed
//   o_framing_err      one-cycle pulse, stop bit failed
//   o_busy             high whenever a frame is in progress
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_in,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_parity_enable,
  uart_rx_ctrl_if.master        chk,
  output logic                  o_data_valid,
  output logic                  o_parity_err_flag,
  output logic                  o_framing_err,
  output logic                  o_busy
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(8);

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  sticky_q, sticky_d;
  logic                  start_en_q, start_en_d;
  logic                  parity_en_q, parity_en_d;
  logic                  stop_en_q, stop_en_d;
  logic                  deser_q, deser_d;
  logic                  end_now;
  logic                  chk_next, end_next;
  logic                  stop_end;

  assign end_now = (edge_q == prescale_q - PRESCALE_W'(1));

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    sticky_d   = sticky_q;

    if (state_q == IDLE) begin
      edge_d = '0;
      if (!i_rx_in) begin
        state_d    = START;
        prescale_d = (i_prescale < MIN_PRESCALE) ? MIN_PRESCALE : i_prescale;
        par_en_d   = i_parity_enable;
        sticky_d   = 1'b0;
      end
    end else begin
      edge_d = end_now ? '0 : edge_q + PRESCALE_W'(1);
    end

    case (state_q)
      START: if (end_now) begin
        if (chk.i_start_bit_checked) begin
          state_d = DATA;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (end_now) begin
        if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      PARITY: if (end_now) begin
        sticky_d = chk.i_parity_error;
        state_d  = STOP;
      end
      STOP: if (end_now) begin
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  // Strobes are registered, so they are decoded from the next state/edge
  // to land in the same cycle the edge counter shows CHK or END.
  always_comb begin
    chk_next    = (edge_d == prescale_d - PRESCALE_W'(2));
    end_next    = (edge_d == prescale_d - PRESCALE_W'(1));
    start_en_d  = (state_d == START)  && chk_next;
    parity_en_d = (state_d == PARITY) && chk_next;
    stop_en_d   = (state_d == STOP)   && chk_next;
    deser_d     = (state_d == DATA)   && end_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      edge_q      <= '0;
      bit_q       <= '0;
      prescale_q  <= MIN_PRESCALE;
      par_en_q    <= 1'b0;
      sticky_q    <= 1'b0;
      start_en_q  <= 1'b0;
      parity_en_q <= 1'b0;
      stop_en_q   <= 1'b0;
      deser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      bit_q       <= bit_d;
      prescale_q  <= prescale_d;
      par_en_q    <= par_en_d;
      sticky_q    <= sticky_d;
      start_en_q  <= start_en_d;
      parity_en_q <= parity_en_d;
      stop_en_q   <= stop_en_d;
      deser_q     <= deser_d;
    end
  end

  // Checker results arrive one cycle after their CHK strobe, i.e. during
  // END, so the frame verdict is decoded directly in the STOP END cycle.
  assign stop_end          = (state_q == STOP) && end_now;
  assign o_data_valid      = stop_end && !sticky_q && !chk.i_stop_error;
  assign o_parity_err_flag = stop_end && sticky_q;
  assign o_framing_err     = stop_end && chk.i_stop_error;
  assign o_busy            = (state_q != IDLE);

  assign chk.o_data_sample_enable  = (state_q != IDLE);
  assign chk.o_edge_count          = edge_q;
  assign chk.o_start_check_enable  = start_en_q;
  assign chk.o_parity_check_enable = parity_en_q;
  assign chk.o_stop_check_enable   = stop_en_q;
  assign chk.o_deser_enable        = deser_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller FSM for the UART RX path.
- Detects the falling edge of a frame and runs its own oversampling edge counter and bit counter.
- Issues one-cycle enable strobes to the sampler, start/parity/stop checkers and deserializer, then judges the frame from the registered checker results.
- Directly consumes the start-bit checker output (i_start_bit_checked); sits between the RX line and the data-path stages.

Parameters:
- DATA_WIDTH, 8, data bits per frame (1..16).
- PRESCALE_W, 6, width of prescale and edge counter.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_rx_in  input  1  synchronised serial line, idle high
- i_prescale  input  PRESCALE_W  oversampling ratio (8, 16 or 32); latched on frame start
- i_parity_enable  input  1  frame carries a parity bit; latched on frame start
- i_start_bit_checked  input  1  registered start checker result, 1 = valid start bit
- i_parity_error  input  1  registered parity checker result, 1 = error
- i_stop_error  input  1  registered stop checker result, 1 = error
- o_data_sample_enable  output  1  sampler enable, high in every non-IDLE state
- o_edge_count  output  PRESCALE_W  current oversampling edge index
- o_start_check_enable  output  1  start checker strobe
- o_parity_check_enable  output  1  parity checker strobe
- o_stop_check_enable  output  1  stop checker strobe
- o_deser_enable  output  1  deserializer shift strobe
- o_data_valid  output  1  one-cycle pulse, good frame received
- o_parity_err_flag  output  1  one-cycle pulse at frame end, parity failed
- o_framing_err  output  1  one-cycle pulse at frame end, stop bit failed
- o_busy  output  1  high in every non-IDLE state

Behaviour:
- Reset (i_rst_n = 0, asynchronous):
  - state = IDLE; edge and bit counters = 0; latched prescale = 8.
  - All outputs are 0.
- Prescale latch:
  - Latched value is P. Values below 8 are treated as 8.
  - Changes to i_prescale or i_parity_enable during a frame are ignored.
- Edge counter:
  - Counts 0..P-1 in every non-IDLE state, then wraps to 0. Held at 0 in IDLE.
  - Two edges are special: CHK = P-2 and END = P-1.
- Bit counter:
  - Counts 0..DATA_WIDTH-1 in DATA, incrementing at END.
  - Cleared on entry to DATA.
- States and transitions:
  - IDLE: when i_rx_in = 0, latch P and parity enable, go to START. The first START cycle has edge 0.
  - START:
    - o_start_check_enable = 1 at CHK only.
    - At END: i_start_bit_checked = 1 -> DATA; else -> IDLE (glitch rejection, no status pulse).
  - DATA:
    - o_deser_enable = 1 at END.
    - At END with bit count = DATA_WIDTH-1: go to PARITY if parity is enabled, else STOP.
  - PARITY:
    - o_parity_check_enable = 1 at CHK.
    - At END: capture i_parity_error into an internal sticky flag, then go to STOP.
  - STOP:
    - o_stop_check_enable = 1 at CHK.
    - At END, go to IDLE and pulse for one cycle:
      - o_data_valid if sticky parity = 0 and i_stop_error = 0;
      - o_parity_err_flag if sticky parity = 1;
      - o_framing_err if i_stop_error = 1.
    - Both error pulses may assert in the same cycle.
- Output timing:
  - Strobe outputs are registered and high for exactly one cycle at the stated edge.
  - Checker results are read one cycle later, at END.
- Sticky parity flag:
  - Cleared on every IDLE -> START transition.
- Back-to-back frames:
  - IDLE is held for at least one cycle after STOP. A low line in that cycle starts the next frame.
- Reset mid-frame:
  - Immediate return to IDLE, no status pulses.

Test Plan:
- P=8, no parity, byte 0xA5, line falls at cycle T -> START at T+1, o_start_check_enable at T+7, 8 o_deser_enable pulses at T+16, T+24 … T+72, o_data_valid at T+80 only.
- P=8, parity enabled, good frame -> o_parity_check_enable at T+79, o_data_valid at T+88, both error outputs 0.
- Low glitch, with i_start_bit_checked = 0 at END of START -> back to IDLE at T+9, no o_deser_enable, no status pulses.
- i_stop_error = 1 at STOP END (P=16, no parity) -> o_framing_err pulses at T+160, o_data_valid stays 0.
- i_parity_error = 1 in PARITY, stop OK -> o_parity_err_flag at T+88, o_data_valid 0. The next clean frame gives o_data_valid, confirming the sticky flag cleared.
- i_rst_n asserted mid-DATA -> all outputs 0 immediately. i_prescale changed mid-frame -> timing unchanged until the next frame.
